// File: rtl/cp0_except_ctrl.sv
// cp0_except_ctrl: MEM-stage interrupt/exception detection, CP0 update, flush sequencing and IF redirect.
// Optional taken-exception counter on exc_count_o, enabled by defining CP0_EXC_CNT_EN.
module cp0_except_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [5:0]  mem_exc_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  input  logic        redirect_ready_i,
  output logic [31:0] new_pc_o,
  output logic [31:0] exc_count_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  localparam logic [XLEN-1:0] CODE_INT  = XLEN'(32'h1);
  localparam logic [XLEN-1:0] CODE_RI   = XLEN'(32'ha);
  localparam logic [XLEN-1:0] CODE_SYS  = XLEN'(32'h8);
  localparam logic [XLEN-1:0] CODE_BRK  = XLEN'(32'h9);
  localparam logic [XLEN-1:0] CODE_TRAP = XLEN'(32'hd);
  localparam logic [XLEN-1:0] CODE_OV   = XLEN'(32'hc);
  localparam logic [XLEN-1:0] CODE_ERET = XLEN'(32'he);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   npc_q, npc_d;
  logic [XLEN-1:0]   exc_d, addr_d, new_pc_d;
  logic              ds_d, flush_d, rv_d;

  logic [XLEN-1:0]   status_fwd, epc_fwd;
  logic [7:0]        cause_ip;
  logic              int_pend;
  logic [XLEN-1:0]   code;
  logic              det;
  logic              unused_bits;

  // WB-stage MTC0 forwarding; a Cause write only reaches the software interrupt bits
  always_comb begin
    status_fwd = cp0_status_i;
    epc_fwd    = cp0_epc_i;
    cause_ip   = cp0_cause_i[15:8];
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        REG_STATUS: status_fwd    = wb_cp0_data_i;
        REG_CAUSE:  cause_ip[1:0] = wb_cp0_data_i[9:8];
        REG_EPC:    epc_fwd       = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

  assign unused_bits = ^{status_fwd[31:16], status_fwd[7:2], cp0_cause_i[31:16], cp0_cause_i[7:0]};

  // Priority resolution: interrupt first, ERET last
  always_comb begin
    int_pend = (|(cause_ip & status_fwd[15:8])) & status_fwd[0] & ~status_fwd[1];
    code     = '0;
    if (int_pend)          code = CODE_INT;
    else if (mem_exc_i[0]) code = CODE_RI;
    else if (mem_exc_i[1]) code = CODE_SYS;
    else if (mem_exc_i[2]) code = CODE_BRK;
    else if (mem_exc_i[3]) code = CODE_TRAP;
    else if (mem_exc_i[4]) code = CODE_OV;
    else if (mem_exc_i[5]) code = CODE_ERET;
  end

  assign det = (state_q == IDLE) && mem_valid_i && (code != '0);

  // Next-state and registered-output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    npc_d    = npc_q;
    exc_d    = '0;
    addr_d   = '0;
    ds_d     = 1'b0;
    flush_d  = 1'b0;
    rv_d     = 1'b0;
    new_pc_d = '0;
    case (state_q)
      IDLE: begin
        if (det) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          npc_d   = (code == CODE_ERET) ? epc_fwd : EXC_VECTOR;
          exc_d   = code;
          addr_d  = mem_pc_i;
          ds_d    = mem_in_delayslot_i;
          flush_d = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d  = REDIRECT;
          rv_d     = 1'b1;
          new_pc_d = npc_q;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          flush_d = 1'b1;
        end
      end
      REDIRECT: begin
        if (redirect_ready_i) begin
          state_d = IDLE;
        end else begin
          rv_d     = 1'b1;
          new_pc_d = npc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      npc_q               <= '0;
      excepttype_o        <= '0;
      current_inst_addr_o <= '0;
      is_in_delayslot_o   <= 1'b0;
      flush_o             <= 1'b0;
      redirect_valid_o    <= 1'b0;
      new_pc_o            <= '0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      npc_q               <= npc_d;
      excepttype_o        <= exc_d;
      current_inst_addr_o <= addr_d;
      is_in_delayslot_o   <= ds_d;
      flush_o             <= flush_d;
      redirect_valid_o    <= rv_d;
      new_pc_o            <= new_pc_d;
    end
  end

`ifdef CP0_EXC_CNT_EN
  logic [XLEN-1:0] exc_cnt_q;

  // ERET returns from an exception rather than taking one, so it is not counted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_cnt_q <= '0;
    end else if (det && (code != CODE_ERET)) begin
      exc_cnt_q <= exc_cnt_q + XLEN'(1);
    end
  end

  assign exc_count_o = exc_cnt_q;
`else
  assign exc_count_o = '0;
`endif

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Scoreboard bench for cp0_except_ctrl: instance a uses FLUSH_CYCLES=1, instance b uses FLUSH_CYCLES=3.
`timescale 1ns/1ps
module tb_cp0_except_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_pc, status, cause, epc, wb_data;
  logic        mem_ds, wb_we;
  logic [5:0]  mem_exc;
  logic [4:0]  wb_addr;
  logic        valid_a, ready_a, valid_b, ready_b;
  logic [31:0] exc_a, addr_a, npc_a, cnt_a, exc_b, addr_b, npc_b, cnt_b;
  logic        ds_a, flush_a, rv_a, ds_b, flush_b, rv_b;

  typedef struct {
    logic [31:0] code;
    logic [31:0] addr;
    logic        ds;
    logic [31:0] npc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  cp0_except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .mem_valid_i(valid_a), .mem_pc_i(mem_pc), .mem_in_delayslot_i(mem_ds),
    .mem_exc_i(mem_exc), .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
    .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_addr), .wb_cp0_data_i(wb_data),
    .excepttype_o(exc_a), .current_inst_addr_o(addr_a), .is_in_delayslot_o(ds_a), .flush_o(flush_a),
    .redirect_valid_o(rv_a), .redirect_ready_i(ready_a), .new_pc_o(npc_a), .exc_count_o(cnt_a));

  cp0_except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .mem_valid_i(valid_b), .mem_pc_i(mem_pc), .mem_in_delayslot_i(mem_ds),
    .mem_exc_i(mem_exc), .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
    .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_addr), .wb_cp0_data_i(wb_data),
    .excepttype_o(exc_b), .current_inst_addr_o(addr_b), .is_in_delayslot_o(ds_b), .flush_o(flush_b),
    .redirect_valid_o(rv_b), .redirect_ready_i(ready_b), .new_pc_o(npc_b), .exc_count_o(cnt_b));

  // Present one MEM instruction to instance a for a single cycle; returns at the first post-event sample point
  task automatic issue_a(input logic [5:0] exc, input logic [31:0] pc, input logic ds,
                         input exp_t e, input bit push);
    @(negedge clk);
    mem_exc = exc; mem_pc = pc; mem_ds = ds; valid_a = 1'b1;
    if (push) begin
      sb.push_back(e);
      if (e.code != 32'he) exp_cnt++;
    end
    @(negedge clk);
    valid_a = 1'b0; mem_exc = '0;
  endtask

  task automatic wait_valid_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rv_a) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({exc_a, addr_a, ds_a, flush_a, rv_a, npc_a, cnt_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got exc=%h addr=%h ds=%b fl=%b rv=%b npc=%h cnt=%h want all 0",
               exc_a, addr_a, ds_a, flush_a, rv_a, npc_a, cnt_a);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({exc_b, flush_b, rv_b, npc_b} !== '0) begin
      errors++;
      $display("FAIL reset_idle_b: got exc=%h fl=%b rv=%b npc=%h want all 0", exc_b, flush_b, rv_b, npc_b);
    end
  endtask

  task automatic test_syscall;
    exp_t e;
    ready_a = 1'b1;
    issue_a(6'b000010, 32'hBFC00100, 1'b0, exp_t'{32'h8, 32'hBFC00100, 1'b0, VEC}, 1'b1);
    e = sb.pop_front();
    checks++;
    if (exc_a !== e.code) begin
      errors++;
      $display("FAIL sys_code: got %h want %h", exc_a, e.code);
    end
    checks++;
    if (addr_a !== e.addr || ds_a !== e.ds || flush_a !== 1'b1) begin
      errors++;
      $display("FAIL sys_addr_ds_flush: got %h/%b/%b want %h/%b/1", addr_a, ds_a, flush_a, e.addr, e.ds);
    end
    @(negedge clk);
    checks++;
    if (flush_a !== 1'b0 || exc_a !== '0 || rv_a !== 1'b1 || npc_a !== e.npc) begin
      errors++;
      $display("FAIL sys_redirect: got fl=%b exc=%h rv=%b npc=%h want 0/0/1/%h", flush_a, exc_a, rv_a, npc_a, e.npc);
    end
    @(negedge clk);
    checks++;
    if (rv_a !== 1'b0 || npc_a !== '0) begin
      errors++;
      $display("FAIL sys_accept: got rv=%b npc=%h want 0/0", rv_a, npc_a);
    end
  endtask

  task automatic test_priority;
    logic [5:0]  fl [4];
    logic [31:0] cd [4];
    logic [31:0] pc;
    logic        ds;
    exp_t        e;
    bit          ok;
    fl[0] = 6'b010001; cd[0] = 32'ha;
    fl[1] = 6'b001100; cd[1] = 32'h9;
    fl[2] = 6'b011000; cd[2] = 32'hd;
    fl[3] = 6'b110000; cd[3] = 32'hc;
    ready_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h80000024 + 32'(i * 4);
      ds = (i == 0) || (i == 3);
      issue_a(fl[i], pc, ds, exp_t'{cd[i], pc, ds, VEC}, 1'b1);
      e = sb.pop_front();
      checks++;
      if (exc_a !== e.code || addr_a !== e.addr || ds_a !== e.ds) begin
        errors++;
        $display("FAIL prio_%0d: got %h/%h/%b want %h/%h/%b", i, exc_a, addr_a, ds_a, e.code, e.addr, e.ds);
      end
      wait_valid_a(ok);
      checks++;
      if (!ok || npc_a !== e.npc) begin
        errors++;
        $display("FAIL prio_npc_%0d: got ok=%b npc=%h want 1/%h", i, ok, npc_a, e.npc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_interrupt;
    exp_t e;
    bit   ok;
    ready_a = 1'b1;
    status = 32'h00000401; cause = 32'h00000400;
    issue_a(6'b000000, 32'h80000100, 1'b0, exp_t'{32'h1, 32'h80000100, 1'b0, VEC}, 1'b1);
    e = sb.pop_front();
    checks++;
    if (exc_a !== e.code) begin
      errors++;
      $display("FAIL int_code: got %h want %h", exc_a, e.code);
    end
    wait_valid_a(ok);
    @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (exc_a !== '0 || flush_a !== 1'b0) begin
      errors++;
      $display("FAIL int_novalid: got exc=%h fl=%b want 0/0", exc_a, flush_a);
    end
    status = 32'h00000403;
    issue_a(6'b000000, 32'h80000104, 1'b0, exp_t'{32'h0, 32'h0, 1'b0, 32'h0}, 1'b0);
    checks++;
    if (exc_a !== '0 || flush_a !== 1'b0) begin
      errors++;
      $display("FAIL int_exl_mask: got exc=%h fl=%b want 0/0", exc_a, flush_a);
    end
    issue_a(6'b000010, 32'h80000108, 1'b1, exp_t'{32'h8, 32'h80000108, 1'b1, VEC}, 1'b1);
    e = sb.pop_front();
    checks++;
    if (exc_a !== e.code || ds_a !== e.ds) begin
      errors++;
      $display("FAIL exl_sys: got %h/%b want %h/%b", exc_a, ds_a, e.code, e.ds);
    end
    wait_valid_a(ok);
    @(negedge clk);
    status = '0; cause = '0;
  endtask

  task automatic test_forwarding;
    exp_t e;
    bit   ok;
    ready_a = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd14; wb_data = 32'h80001000; epc = 32'h80000000;
    issue_a(6'b100000, 32'h80000200, 1'b0, exp_t'{32'he, 32'h80000200, 1'b0, 32'h80001000}, 1'b1);
    wb_we = 1'b0;
    e = sb.pop_front();
    checks++;
    if (exc_a !== e.code) begin
      errors++;
      $display("FAIL eret_code: got %h want %h", exc_a, e.code);
    end
    wait_valid_a(ok);
    checks++;
    if (!ok || npc_a !== e.npc) begin
      errors++;
      $display("FAIL eret_npc: got ok=%b npc=%h want 1/%h", ok, npc_a, e.npc);
    end
    @(negedge clk);
    status = 32'h00000201; wb_we = 1'b1; wb_addr = 5'd13; wb_data = 32'h00000200;
    issue_a(6'b000000, 32'h80000300, 1'b0, exp_t'{32'h1, 32'h80000300, 1'b0, VEC}, 1'b1);
    e = sb.pop_front();
    checks++;
    if (exc_a !== e.code) begin
      errors++;
      $display("FAIL fwd_cause: got %h want %h", exc_a, e.code);
    end
    wait_valid_a(ok);
    @(negedge clk);
    status = 32'h00000401; wb_data = 32'h00000400;
    issue_a(6'b000000, 32'h80000304, 1'b0, exp_t'{32'h0, 32'h0, 1'b0, 32'h0}, 1'b0);
    checks++;
    if (exc_a !== '0) begin
      errors++;
      $display("FAIL fwd_cause_ip_only: got %h want 0", exc_a);
    end
    status = '0; cause = 32'h00000400; wb_addr = 5'd12; wb_data = 32'h00000401;
    issue_a(6'b000000, 32'h80000308, 1'b0, exp_t'{32'h1, 32'h80000308, 1'b0, VEC}, 1'b1);
    wb_we = 1'b0;
    e = sb.pop_front();
    checks++;
    if (exc_a !== e.code) begin
      errors++;
      $display("FAIL fwd_status: got %h want %h", exc_a, e.code);
    end
    wait_valid_a(ok);
    @(negedge clk);
    status = '0; cause = '0;
  endtask

  task automatic test_flush_hold;
    exp_t e;
    @(negedge clk);
    mem_exc = 6'b000100; mem_pc = 32'h80000400; mem_ds = 1'b0; valid_b = 1'b1; ready_b = 1'b0;
    sb.push_back(exp_t'{32'h9, 32'h80000400, 1'b0, VEC});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (exc_b !== e.code || addr_b !== e.addr || flush_b !== 1'b1) begin
      errors++;
      $display("FAIL b_first: got %h/%h/%b want %h/%h/1", exc_b, addr_b, flush_b, e.code, e.addr);
    end
    mem_exc = 6'b000010;
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (flush_b !== 1'b1 || exc_b !== '0 || rv_b !== 1'b0) begin
        errors++;
        $display("FAIL b_flush_%0d: got fl=%b exc=%h rv=%b want 1/0/0", k, flush_b, exc_b, rv_b);
      end
    end
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (flush_b !== 1'b0 || rv_b !== 1'b1 || npc_b !== e.npc || exc_b !== '0) begin
        errors++;
        $display("FAIL b_hold_%0d: got fl=%b rv=%b npc=%h exc=%h want 0/1/%h/0", k, flush_b, rv_b, npc_b, exc_b, e.npc);
      end
    end
    ready_b = 1'b1; valid_b = 1'b0; mem_exc = '0;
    @(negedge clk);
    ready_b = 1'b0;
    checks++;
    if (rv_b !== 1'b0) begin
      errors++;
      $display("FAIL b_accept: got rv=%b want 0", rv_b);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exc_b !== '0 || flush_b !== 1'b0 || rv_b !== 1'b0) begin
      errors++;
      $display("FAIL b_single: got exc=%h fl=%b rv=%b want 0/0/0", exc_b, flush_b, rv_b);
    end
  endtask

  task automatic test_count;
    logic [31:0] want;
`ifdef CP0_EXC_CNT_EN
    want = 32'(exp_cnt);
`else
    want = 32'h0;
`endif
    checks++;
    if (cnt_a !== want) begin
      errors++;
      $display("FAIL exc_count: got %0d want %0d", cnt_a, want);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    @(negedge clk);
    ready_a = 1'b0; ready_b = 1'b0;
    mem_exc = 6'b000010; mem_pc = 32'h80000500; valid_a = 1'b1; valid_b = 1'b1;
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0; mem_exc = '0;
    wait_valid_a(ok);
    checks++;
    if (!ok || flush_b !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got rv_a=%b fl_b=%b want 1/1", rv_a, flush_b);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({exc_a, addr_a, ds_a, flush_a, rv_a, npc_a, cnt_a, exc_b, flush_b, rv_b, npc_b, cnt_b} !== '0) begin
      errors++;
      $display("FAIL async_reset: got rv_a=%b npc_a=%h fl_b=%b cnt_a=%h want all 0", rv_a, npc_a, flush_b, cnt_a);
    end
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (rv_a !== 1'b0 || rv_b !== 1'b0 || flush_a !== 1'b0 || flush_b !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: got rv=%b/%b fl=%b/%b want 0", rv_a, rv_b, flush_a, flush_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_pc = '0; mem_ds = 1'b0; mem_exc = '0;
    status = '0; cause = '0; epc = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    valid_a = 1'b0; ready_a = 1'b0; valid_b = 1'b0; ready_b = 1'b0;
    test_reset();
    test_syscall();
    test_priority();
    test_interrupt();
    test_forwarding();
    test_flush_hold();
    test_count();
    test_reset_mid();
    test_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
